rx_serial_7o1: RTL and testbench

UART receiver for 7O1 frames: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit, at 115200 baud from a 50 MHz clock. It sits directly downstream of the team's 7O1 transmitter on the serial link. It deserialises each frame into a 7-bit ASCII character, checks parity, and holds the result for a consumer using a simple valid/acknowledge flag.

---
 rtl/rx_serial_7o1_pkg.sv | 24 ++
 rtl/contador_m.sv | 44 ++++
 rtl/rx_serial_7o1_uc.sv | 65 ++++++
 rtl/rx_serial_7o1.sv | 184 ++++++++++++++++++
 tb/tb_rx_serial_7o1.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_serial_7o1_pkg.sv
// rx_serial_7o1_pkg: shared definitions for the 7O1 UART receiver.
// Holds the FSM state encoding (4-bit codes, exported on db_estado),
// the frame geometry and the odd-parity helper used by the datapath.
package rx_serial_7o1_pkg;

  localparam int DATA_BITS       = 7;    // ASCII payload bits
  localparam int SHIFT_BITS      = 8;    // payload + parity bit
  localparam int CLK_DIV_DEFAULT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    DATA      = 4'd2,
    STOP      = 4'd3,
    STORE     = 4'd4,
    WAIT_HIGH = 4'd5
  } estado_e;

  // 1 when data+parity hold an odd number of ones (a correct 7O1 frame).
  function automatic logic paridade_impar(input logic [SHIFT_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M free-running counter with mid-point and end flags.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   zera         : synchronous clear (wins over conta)
//   conta        : count enable
//   fim          : count == M-1
//   meio         : count == M/2-1
module contador_m #(
  parameter int M = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  localparam int N    = (M > 1) ? $clog2(M) : 1;
  localparam int HALF = M / 2;

  logic [N-1:0] q_r;

  // Count 0..M-1 and wrap; synchronous clear has priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (zera) begin
      q_r <= '0;
    end else if (conta) begin
      if (q_r == N'(M - 1)) begin
        q_r <= '0;
      end else begin
        q_r <= q_r + N'(1);
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign fim  = (q_r == N'(M - 1));
  assign meio = (q_r == N'(HALF - 1));

endmodule

// File: rtl/rx_serial_7o1_uc.sv
// rx_serial_7o1_uc: control FSM of the 7O1 receiver.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   rxs          : synchronised serial line
//   meio, fim    : baud counter mid-bit / end-of-bit flags
//   ultimo_bit   : the next DATA sample is the 8th (parity) sample
//   stop_bit     : captured stop-bit value, valid in STORE
//   estado       : registered state (debug / datapath decode)
//   pronto       : registered 1-cycle pulse, high the cycle after STORE
module rx_serial_7o1_uc
  import rx_serial_7o1_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    rxs,
  input  logic    meio,
  input  logic    fim,
  input  logic    ultimo_bit,
  input  logic    stop_bit,
  output estado_e estado,
  output logic    pronto
);

  // State transitions and the registered pronto pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      pronto <= 1'b0;
    end else begin
      // pronto lines up with the output registers written at the end of STORE
      pronto <= (estado == STORE);
      case (estado)
        IDLE: begin
          if (!rxs) estado <= START;
          else      estado <= IDLE;
        end
        START: begin
          // a start bit must still be low at its mid-point, else it was a glitch
          if (meio) estado <= rxs ? IDLE : DATA;
          else      estado <= START;
        end
        DATA: begin
          if (fim && ultimo_bit) estado <= STOP;
          else                   estado <= DATA;
        end
        STOP: begin
          if (fim) estado <= STORE;
          else     estado <= STOP;
        end
        STORE: begin
          // a low stop bit means the line may be stuck low: wait for idle
          estado <= stop_bit ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rxs) estado <= IDLE;
          else     estado <= WAIT_HIGH;
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// rx_serial_7o1: UART receiver for 7O1 frames (start, 7 data LSB first,
// odd parity, stop). Holds the last character behind a valid/ack flag.
// Optional feature macro: RX_SERIAL_FRAME_ERR_EN adds erro_frame and
// suppresses tem_dado for frames with a bad stop bit.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   dado_serial    : serial line (idles high, asynchronous)
//   recebe_dado    : consumer acknowledge, clears tem_dado
//   dados_ascii    : last received character
//   paridade_ok    : last frame had odd parity over data+parity
//   tem_dado       : character available, not yet acknowledged
//   pronto         : 1-cycle pulse when a frame has been stored
//   db_estado      : FSM state code
//   db_dado_serial : synchronised line
//   erro_frame     : (optional) last frame had a low stop bit
module rx_serial_7o1
  import rx_serial_7o1_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe_dado,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 paridade_ok,
  output logic                 tem_dado,
  output logic                 pronto,
  output logic [3:0]           db_estado,
  output logic                 db_dado_serial
`ifdef RX_SERIAL_FRAME_ERR_EN
  ,
  output logic                 erro_frame
`endif
);

  logic [1:0]            sync_r;
  logic [SHIFT_BITS-1:0] shift_r;
  logic [3:0]            bit_cnt_r;
  logic                  stop_r;
  logic [DATA_BITS-1:0]  dados_r;
  logic                  paridade_r;
  logic                  tem_r;
  logic                  rxs_s;
  logic                  meio_s;
  logic                  fim_s;
  logic                  zera_s;
  logic                  shift_en_s;
  logic                  stop_cap_s;
  logic                  store_s;
  logic                  ultimo_bit_s;
  logic                  pronto_s;
  estado_e               estado_s;

  assign rxs_s        = sync_r[1];
  // counter idles at 0 and restarts at the start-bit mid-point so that
  // every later fim falls in the middle of a bit cell
  assign zera_s       = (estado_s == IDLE) || ((estado_s == START) && meio_s);
  assign shift_en_s   = (estado_s == DATA) && fim_s;
  assign stop_cap_s   = (estado_s == STOP) && fim_s;
  assign store_s      = (estado_s == STORE);
  assign ultimo_bit_s = (bit_cnt_r == 4'(SHIFT_BITS - 1));

  contador_m #(
    .M (CLK_DIV)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .zera  (zera_s),
    .conta (1'b1),
    .fim   (fim_s),
    .meio  (meio_s)
  );

  rx_serial_7o1_uc u_uc (
    .clock      (clock),
    .reset      (reset),
    .rxs        (rxs_s),
    .meio       (meio_s),
    .fim        (fim_s),
    .ultimo_bit (ultimo_bit_s),
    .stop_bit   (stop_r),
    .estado     (estado_s),
    .pronto     (pronto_s)
  );

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], dado_serial};
    end
  end

  // Deserialiser: right shift (LSB arrives first), bit count, stop capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_r   <= '0;
      bit_cnt_r <= 4'd0;
      stop_r    <= 1'b1;
    end else begin
      if (shift_en_s) begin
        shift_r <= {rxs_s, shift_r[SHIFT_BITS-1:1]};
      end else begin
        shift_r <= shift_r;
      end
      if (estado_s == IDLE) begin
        bit_cnt_r <= 4'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (stop_cap_s) begin
        stop_r <= rxs_s;
      end else begin
        stop_r <= stop_r;
      end
    end
  end

  // Output registers: character and parity change only in STORE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados_r    <= '0;
      paridade_r <= 1'b0;
    end else if (store_s) begin
      dados_r    <= shift_r[DATA_BITS-1:0];
      paridade_r <= paridade_impar(shift_r);
    end else begin
      dados_r    <= dados_r;
      paridade_r <= paridade_r;
    end
  end

`ifdef RX_SERIAL_FRAME_ERR_EN
  logic erro_r;

  // Frame-error flag and availability flag; a bad stop bit does not set tem_dado.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_r <= 1'b0;
      tem_r  <= 1'b0;
    end else begin
      if (store_s) begin
        erro_r <= ~stop_r;
      end else begin
        erro_r <= erro_r;
      end
      if (store_s && stop_r) begin
        tem_r <= 1'b1;
      end else if (recebe_dado) begin
        tem_r <= 1'b0;
      end else begin
        tem_r <= tem_r;
      end
    end
  end

  assign erro_frame = erro_r;
`else
  // Availability flag: set in STORE (wins over a same-cycle acknowledge).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tem_r <= 1'b0;
    end else if (store_s) begin
      tem_r <= 1'b1;
    end else if (recebe_dado) begin
      tem_r <= 1'b0;
    end else begin
      tem_r <= tem_r;
    end
  end
`endif

  assign dados_ascii    = dados_r;
  assign paridade_ok    = paridade_r;
  assign tem_dado       = tem_r;
  assign pronto         = pronto_s;
  assign db_estado      = estado_s;
  assign db_dado_serial = rxs_s;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// tb_rx_serial_7o1: scoreboard bench for rx_serial_7o1 with CLK_DIV=8.
// The stimulus side serialises frames and pushes the expected character,
// parity verdict and flags; a monitor pops and compares on every pronto.
module tb_rx_serial_7o1;

  localparam int CLK_DIV = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dado_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       paridade_ok;
  logic       tem_dado;
  logic       pronto;
  logic [3:0] db_estado;
  logic       db_dado_serial;
`ifdef RX_SERIAL_FRAME_ERR_EN
  logic       erro_frame;
`endif

  typedef struct {
    logic [6:0] d;
    logic       pok;
    logic       tem;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       exp_tem = 1'b0;
  logic [6:0] prev_d = 7'd0;
  logic       prev_pok = 1'b0;

  rx_serial_7o1 #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dado_serial    (dado_serial),
    .recebe_dado    (recebe_dado),
    .dados_ascii    (dados_ascii),
    .paridade_ok    (paridade_ok),
    .tem_dado       (tem_dado),
    .pronto         (pronto),
    .db_estado      (db_estado),
`ifdef RX_SERIAL_FRAME_ERR_EN
    .erro_frame     (erro_frame),
`endif
    .db_dado_serial (db_dado_serial)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    dado_serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [9:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dado_serial = bits[i];
      repeat (CLK_DIV) @(negedge clock);
    end
  endtask

  // Reference model: odd parity verdict is simply the XOR of all 8 bits received.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
    exp_t e;
    e.d   = d;
    e.pok = ^{p, d};
`ifdef RX_SERIAL_FRAME_ERR_EN
    e.err = ~s;
    e.tem = s ? 1'b1 : exp_tem;
`else
    e.err = 1'b0;
    e.tem = 1'b1;
`endif
    exp_tem = e.tem;
    sb.push_back(e);
    send_bits({s, p, d, 1'b0}, 10);
  endtask

  task automatic ack();
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;
    exp_tem = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pronto) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pronto: got pronto=1 data=0x%0h, expected no frame", dados_ascii);
          end else begin
            e = sb.pop_front();
            check("data", 8'(dados_ascii), 8'(e.d));
            check("parity_ok", 8'(paridade_ok), 8'(e.pok));
            check("tem_dado_at_pronto", 8'(tem_dado), 8'(e.tem));
`ifdef RX_SERIAL_FRAME_ERR_EN
            check("erro_frame", 8'(erro_frame), 8'(e.err));
`endif
          end
        end else if (dados_ascii !== prev_d || paridade_ok !== prev_pok) begin
          miscompares++;
          $display("FAIL output_hold: got data=0x%0h pok=%0b without pronto, expected 0x%0h/%0b",
                   dados_ascii, paridade_ok, prev_d, prev_pok);
        end
      end
      prev_d   = dados_ascii;
      prev_pok = paridade_ok;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_data", 8'(dados_ascii), 8'h00);
    check("rst_pok", 8'(paridade_ok), 8'h00);
    check("rst_tem", 8'(tem_dado), 8'h00);
    check("rst_pronto", 8'(pronto), 8'h00);
    check("rst_state", 8'(db_estado), 8'h00);
    check("rst_sync", 8'(db_dado_serial), 8'h01);
    reset = 1'b0;
    idle(5);

    // 'A' with correct parity
    send_frame(7'h41, 1'b1, 1'b1);
    idle(3);
    check("A_tem", 8'(tem_dado), 8'h01);
    check("A_data", 8'(dados_ascii), 8'h41);
    ack();
    check("ack_clears_tem", 8'(tem_dado), 8'h00);

    // back-to-back frames, no idle gap
    send_frame(7'h7F, 1'b0, 1'b1);
    send_frame(7'h35, 1'b1, 1'b1);
    idle(3);
    check("b2b_data", 8'(dados_ascii), 8'h35);
    check("b2b_pok", 8'(paridade_ok), 8'h01);

    // bad parity
    send_frame(7'h41, 1'b0, 1'b1);
    idle(3);
    check("badpar_pok", 8'(paridade_ok), 8'h00);

    // 3-clock low glitch must be rejected
    dado_serial = 1'b0;
    repeat (3) @(negedge clock);
    idle(20);
    check("glitch_state", 8'(db_estado), 8'h00);
    check("glitch_data", 8'(dados_ascii), 8'h41);
    check("glitch_pok", 8'(paridade_ok), 8'h00);

    // reset after the 4th data bit of 0x55
    send_bits(10'b00000_01010, 5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_data", 8'(dados_ascii), 8'h00);
    check("midrst_pok", 8'(paridade_ok), 8'h00);
    check("midrst_tem", 8'(tem_dado), 8'h00);
    check("midrst_pronto", 8'(pronto), 8'h00);
    check("midrst_state", 8'(db_estado), 8'h00);
    dado_serial = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_tem = 1'b0;
    idle(5);
    send_frame(7'h2A, 1'b0, 1'b1);
    idle(3);
    check("after_rst_data", 8'(dados_ascii), 8'h2A);
    check("after_rst_pok", 8'(paridade_ok), 8'h01);

    // acknowledge in the same cycle as STORE: set wins
    fork
      send_frame(7'h33, 1'b1, 1'b1);
      begin
        int n;
        n = 0;
        while (db_estado !== 4'd4 && n < 200) begin
          @(negedge clock);
          n++;
        end
        if (n >= 200) begin
          vectors++;
          miscompares++;
          $display("FAIL store_wait: got no STORE state within 200 cycles, expected state 4");
        end else begin
          recebe_dado = 1'b1;
          @(negedge clock);
          recebe_dado = 1'b0;
        end
      end
    join
    idle(3);
    check("store_ack_tem", 8'(tem_dado), 8'h01);

    // randomized frames with random gaps and acknowledges
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) ack();
      idle($urandom_range(0, 6));
      send_frame(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b1);
    end
    idle(3);
    check("rand_tem", 8'(tem_dado), 8'h01);

    // low stop bit with the line staying low
    ack();
    send_frame(7'h5A, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    check("badstop_state", 8'(db_estado), 8'h05);
    check("badstop_tem", 8'(tem_dado), 8'(exp_tem));
    dado_serial = 1'b1;
    repeat (5) @(negedge clock);
    check("badstop_release", 8'(db_estado), 8'h00);

    // clean frame afterwards
    send_frame(7'h2B, 1'b1, 1'b1);
    idle(5);
    check("final_data", 8'(dados_ascii), 8'h2B);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
